// File: rtl/vending_pkg.sv
// Shared definitions for the vending cart controller: one-hot states, coin
// denominations and the goods price table.
package vending_pkg;

   typedef enum logic [4:0] {
      S_IDLE    = 5'b00001,
      S_SELECT  = 5'b00010,
      S_PAYMENT = 5'b00100,
      S_HOLD    = 5'b01000,
      S_CHANGE  = 5'b10000
   } state_t;

   localparam int NUM_COINS = 5;
   localparam int DENOM_W   = 6;
   localparam int PRICE_W   = 4;

   localparam int COIN_1  = 0;
   localparam int COIN_5  = 1;
   localparam int COIN_10 = 2;
   localparam int COIN_20 = 3;
   localparam int COIN_50 = 4;

   localparam logic [NUM_COINS-1:0][DENOM_W-1:0] DENOM = {6'd50, 6'd20, 6'd10, 6'd5, 6'd1};

   // Goods codes are row/column digits, so an octal literal reads like the label.
   function automatic logic [PRICE_W-1:0] price_lookup(input logic [5:0] code);
      case (code)
         6'o11: return 4'd3;
         6'o12: return 4'd4;
         6'o13: return 4'd6;
         6'o14: return 4'd3;
         6'o21: return 4'd10;
         6'o22: return 4'd8;
         6'o23: return 4'd9;
         6'o24: return 4'd7;
         6'o31: return 4'd4;
         6'o32: return 4'd6;
         6'o33: return 4'd15;
         6'o34: return 4'd8;
         6'o41: return 4'd9;
         6'o42: return 4'd4;
         6'o43: return 4'd5;
         6'o44: return 4'd5;
         default: return '0;
      endcase
   endfunction

   function automatic logic [DENOM_W-1:0] coin_value(input logic [NUM_COINS-1:0] coin);
      logic [DENOM_W-1:0] value;
      value = '0;
      for (int i = NUM_COINS - 1; i >= 0; i--)
         if (coin[i]) value = DENOM[i];
      return value;
   endfunction

endpackage

// File: rtl/vending_cart_fsm_if.sv
// Button/switch and display-side signal bundle of the vending cart controller.
// master drives the front-end pulses, slave is the controller itself.
interface vending_cart_fsm_if #(
   parameter int MAX_ITEMS = 4,
   parameter int QTY_W     = 2,
   parameter int MONEY_W   = 8
);
   localparam int CNT_W = $clog2(MAX_ITEMS + 1);

   logic               sys_Goods;
   logic               sys_Confirm;
   logic               sys_Cancel;
   logic               sys_Change;
   logic [4:0]         coin_in;
   logic [2:0]         type_SW_high;
   logic [2:0]         type_SW_low;
   logic [QTY_W-1:0]   num_SW;
   logic [MONEY_W-1:0] input_money;
   logic [MONEY_W-1:0] need_money;
   logic [MONEY_W-1:0] change_money;
   logic [CNT_W-1:0]   item_count;
   logic [4:0]         state_out;
   logic [4:0]         coin_out;
   logic               err_pulse;
   logic               timeout_pulse;

   modport master (
      output sys_Goods, sys_Confirm, sys_Cancel, sys_Change, coin_in,
             type_SW_high, type_SW_low, num_SW,
      input  input_money, need_money, change_money, item_count,
             state_out, coin_out, err_pulse, timeout_pulse
   );

   modport slave (
      input  sys_Goods, sys_Confirm, sys_Cancel, sys_Change, coin_in,
             type_SW_high, type_SW_low, num_SW,
      output input_money, need_money, change_money, item_count,
             state_out, coin_out, err_pulse, timeout_pulse
   );
endinterface

// File: rtl/vending_change_dispenser.sv
// Greedy change selector: picks the largest denomination not exceeding the
// remaining change (none when the change is zero).
module vending_change_dispenser
   import vending_pkg::*;
#(
   parameter int MONEY_W = 8
)
(
   input  logic [MONEY_W-1:0]   change_money,
   output logic [NUM_COINS-1:0] coin,
   output logic [MONEY_W-1:0]   value
);
   // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      coin  = '0;
      value = '0;
      for (int i = 0; i < NUM_COINS; i++) begin
         if (change_money >= MONEY_W'(DENOM[i])) begin
            coin    = '0;
            coin[i] = 1'b1;
            value   = MONEY_W'(DENOM[i]);
         end
      end
   end
endmodule

// File: rtl/vending_cart_fsm.sv
// LIFO-cart vending controller: select, pay, hold/refund and coin-by-coin change.
// Optional payment inactivity timeout enabled by VENDING_PAY_TIMEOUT_EN.
module vending_cart_fsm
   import vending_pkg::*;
#(
   parameter int MAX_ITEMS      = 4,
   parameter int QTY_W          = 2,
   parameter int MONEY_W        = 8,
   parameter int TIMEOUT_CYCLES = 100_000_000
)
(
   input logic               sys_clk,
   input logic               sys_rst_n,
   vending_cart_fsm_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_ITEMS + 1);
   localparam int SUM_W = MONEY_W + PRICE_W + QTY_W;
   localparam logic [SUM_W-1:0] MONEY_MAX = {{(SUM_W-MONEY_W){1'b0}}, {MONEY_W{1'b1}}};

   state_t               state, state_nxt;
   logic [MONEY_W-1:0]   input_money, input_nxt, need_money, need_nxt, change_money, change_nxt;
   logic [CNT_W-1:0]     item_count, count_nxt, top_idx;
   logic [MONEY_W-1:0]   slot [2**CNT_W];
   logic                 push, clear_cart;
   logic [NUM_COINS-1:0] coin_out, coin_nxt, disp_coin;
   logic [MONEY_W-1:0]   disp_value;
   logic                 err_pulse, err_nxt, timeout_pulse, timeout_nxt;
   logic                 cancel, confirm, goods;
   logic [SUM_W-1:0]     price, need_sum, pay_sum;
   logic                 add_ok, coin_take, coin_reject, expired, timeout_hit;

   assign cancel   = bus.sys_Cancel;
   assign confirm  = bus.sys_Confirm & ~bus.sys_Cancel;
   assign goods    = bus.sys_Goods & ~bus.sys_Confirm & ~bus.sys_Cancel;
   assign top_idx  = item_count - CNT_W'(1);
   assign price    = SUM_W'(price_lookup({bus.type_SW_high, bus.type_SW_low})) * SUM_W'(bus.num_SW);
   assign need_sum = SUM_W'(need_money) + price;
   assign add_ok   = (price != '0) && (item_count != CNT_W'(MAX_ITEMS)) && (need_sum <= MONEY_MAX);
   assign pay_sum  = SUM_W'(input_money) + SUM_W'(coin_value(bus.coin_in));

   // A coin only counts in a PAYMENT cycle that carries no Cancel/Confirm pulse.
   assign coin_take   = (state == S_PAYMENT) && !bus.sys_Cancel && !bus.sys_Confirm
                        && (|bus.coin_in) && (pay_sum <= MONEY_MAX);
   assign coin_reject = (state == S_PAYMENT) && !bus.sys_Cancel && !bus.sys_Confirm
                        && (|bus.coin_in) && (pay_sum > MONEY_MAX);
   assign timeout_hit = expired && !bus.sys_Cancel && !bus.sys_Confirm && !coin_take;

`ifdef VENDING_PAY_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TMO_W-1:0] tmo_cnt;

   assign expired = (state == S_PAYMENT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge sys_clk or posedge sys_rst_n) begin
      if (sys_rst_n)                              tmo_cnt <= '0;
      else if (state != S_PAYMENT || coin_take)   tmo_cnt <= '0;
      else if (!expired)                          tmo_cnt <= tmo_cnt + TMO_W'(1);
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign expired        = 1'b0;
`endif

   vending_change_dispenser #(.MONEY_W(MONEY_W)) u_dispenser (
      .change_money (change_money),
      .coin         (disp_coin),
      .value        (disp_value)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sys_clk or posedge sys_rst_n) begin
      if (sys_rst_n) state <= S_IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (confirm) state_nxt = S_SELECT;
         S_SELECT: begin
            if (cancel && item_count == '0)       state_nxt = S_IDLE;
            else if (confirm && item_count != '0) state_nxt = S_PAYMENT;
         end
         S_PAYMENT: begin
            if (cancel)                                      state_nxt = S_HOLD;
            else if (confirm && input_money >= need_money)   state_nxt = S_CHANGE;
            else if (timeout_hit)                            state_nxt = S_CHANGE;
         end
         S_HOLD: begin
            if (cancel)       state_nxt = S_PAYMENT;
            else if (confirm) state_nxt = S_CHANGE;
         end
         S_CHANGE:  if (bus.sys_Change && change_money == '0) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      input_nxt   = input_money;
      need_nxt    = need_money;
      change_nxt  = change_money;
      count_nxt   = item_count;
      push        = 1'b0;
      clear_cart  = 1'b0;
      coin_nxt    = '0;
      err_nxt     = 1'b0;
      timeout_nxt = 1'b0;
      case (state)
         S_SELECT: begin
            if (cancel) begin
               if (item_count != '0) begin
                  need_nxt  = need_money - slot[top_idx];
                  count_nxt = top_idx;
               end
            end else if (goods) begin
               if (add_ok) begin
                  push      = 1'b1;
                  need_nxt  = MONEY_W'(need_sum);
                  count_nxt = item_count + CNT_W'(1);
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         S_PAYMENT: begin
            if (confirm && input_money >= need_money) change_nxt = input_money - need_money;
            if (coin_take)   input_nxt = MONEY_W'(pay_sum);
            if (coin_reject) err_nxt   = 1'b1;
            if (timeout_hit) begin
               change_nxt  = input_money;
               timeout_nxt = 1'b1;
            end
         end
         S_HOLD:    if (confirm) change_nxt = input_money;
         S_CHANGE: begin
            if (bus.sys_Change) begin
               if (change_money != '0) begin
                  coin_nxt   = disp_coin;
                  change_nxt = change_money - disp_value;
               end else begin
                  input_nxt  = '0;
                  need_nxt   = '0;
                  count_nxt  = '0;
                  clear_cart = 1'b1;
               end
            end
         end
         default: begin
            input_nxt  = '0;
            need_nxt   = '0;
            change_nxt = '0;
            count_nxt  = '0;
            clear_cart = 1'b1;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst_n) begin
      if (sys_rst_n) begin
         input_money   <= '0;
         need_money    <= '0;
         change_money  <= '0;
         item_count    <= '0;
         coin_out      <= '0;
         err_pulse     <= 1'b0;
         timeout_pulse <= 1'b0;
         // NOTE: the cart storage is reset on purpose; an empty cart must hold zero prices.
         for (int i = 0; i < 2**CNT_W; i++) slot[i] <= '0;
      end else begin
         input_money   <= input_nxt;
         need_money    <= need_nxt;
         change_money  <= change_nxt;
         item_count    <= count_nxt;
         coin_out      <= coin_nxt;
         err_pulse     <= err_nxt;
         timeout_pulse <= timeout_nxt;
         if (clear_cart) begin
            for (int i = 0; i < 2**CNT_W; i++) slot[i] <= '0;
         end else if (push) begin
            slot[item_count] <= MONEY_W'(price);
         end
      end
   end

   assign bus.input_money   = input_money;
   assign bus.need_money    = need_money;
   assign bus.change_money  = change_money;
   assign bus.item_count    = item_count;
   assign bus.state_out     = state;
   assign bus.coin_out      = coin_out;
   assign bus.err_pulse     = err_pulse;
   assign bus.timeout_pulse = timeout_pulse;

endmodule

// File: tb/tb_vending_cart_fsm.sv
// Self-checking bench for vending_cart_fsm: directed scenarios plus random
// stimulus against a queue-based behavioural model of the cart and payment.
module tb_vending_cart_fsm;

   localparam int MAX_ITEMS      = 4;
   localparam int QTY_W          = 2;
   localparam int MONEY_W        = 8;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int MONEY_MAX      = (1 << MONEY_W) - 1;

   localparam int M_IDLE = 0, M_SELECT = 1, M_PAY = 2, M_HOLD = 3, M_CHANGE = 4;

   logic sys_clk = 1'b0;
   logic sys_rst_n;

   vending_cart_fsm_if #(.MAX_ITEMS(MAX_ITEMS), .QTY_W(QTY_W), .MONEY_W(MONEY_W)) bus ();

   vending_cart_fsm #(
      .MAX_ITEMS(MAX_ITEMS), .QTY_W(QTY_W), .MONEY_W(MONEY_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int errors = 0;
   int checks = 0;

   int m_mode, m_paid, m_change, m_idle, m_coin, m_err, m_tmo;
   int m_cart[$];
   int denoms[5] = '{1, 5, 10, 20, 50};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int price_of(input int code);
      case (code)
         11: return 3;  12: return 4;  13: return 6;  14: return 3;
         21: return 10; 22: return 8;  23: return 9;  24: return 7;
         31: return 4;  32: return 6;  33: return 15; 34: return 8;
         41: return 9;  42: return 4;  43: return 5;  44: return 5;
         default: return 0;
      endcase
   endfunction

   function automatic int cart_sum();
      int s = 0;
      foreach (m_cart[i]) s += m_cart[i];
      return s;
   endfunction

   function automatic int lowest_coin(input logic [4:0] coin);
      for (int i = 0; i < 5; i++) if (coin[i]) return denoms[i];
      return 0;
   endfunction

   function automatic int largest_idx(input int amount);
      for (int i = 4; i >= 0; i--) if (denoms[i] <= amount) return i;
      return 0;
   endfunction

   function automatic void model_reset();
      m_mode = M_IDLE; m_paid = 0; m_change = 0; m_idle = 0;
      m_coin = 0; m_err = 0; m_tmo = 0;
      m_cart.delete();
   endfunction

   function automatic void model_step(input bit g, cf, cn, ch, input logic [4:0] coin,
                                      input int code, input int qty);
      int p, v, sum, k;
      bit took;
      m_coin = 0; m_err = 0; m_tmo = 0;
      sum = cart_sum();
      case (m_mode)
         M_IDLE: if (cf && !cn) m_mode = M_SELECT;
         M_SELECT: begin
            if (cn) begin
               if (m_cart.size() > 0) void'(m_cart.pop_back());
               else m_mode = M_IDLE;
            end else if (cf) begin
               if (m_cart.size() > 0) begin m_mode = M_PAY; m_idle = 0; end
            end else if (g) begin
               p = price_of(code) * qty;
               if (p == 0 || m_cart.size() >= MAX_ITEMS || sum + p > MONEY_MAX) m_err = 1;
               else m_cart.push_back(p);
            end
         end
         M_PAY: begin
            if (cn) m_mode = M_HOLD;
            else if (cf && m_paid >= sum) begin
               m_change = m_paid - sum;
               m_mode   = M_CHANGE;
            end else begin
               took = 0;
               if (!cf && coin != 0) begin
                  v = lowest_coin(coin);
                  if (m_paid + v > MONEY_MAX) m_err = 1;
                  else begin m_paid += v; took = 1; end
               end
               if (took) m_idle = 0;
               else if (m_idle < TIMEOUT_CYCLES - 1) m_idle++;
`ifdef VENDING_PAY_TIMEOUT_EN
               else if (!cf) begin
                  m_mode = M_CHANGE; m_change = m_paid; m_tmo = 1;
               end
`endif
            end
         end
         M_HOLD: begin
            if (cn) begin m_mode = M_PAY; m_idle = 0; end
            else if (cf) begin m_change = m_paid; m_mode = M_CHANGE; end
         end
         default: begin
            if (ch) begin
               if (m_change > 0) begin
                  k = largest_idx(m_change);
                  m_coin = 1 << k;
                  m_change -= denoms[k];
               end else begin
                  m_mode = M_IDLE; m_paid = 0; m_change = 0;
                  m_cart.delete();
               end
            end
         end
      endcase
   endfunction

   task automatic compare_all();
      check("state_out",     32'(bus.state_out),     32'(1 << m_mode));
      check("input_money",   32'(bus.input_money),   m_paid);
      check("need_money",    32'(bus.need_money),    cart_sum());
      check("change_money",  32'(bus.change_money),  m_change);
      check("item_count",    32'(bus.item_count),    m_cart.size());
      check("coin_out",      32'(bus.coin_out),      m_coin);
      check("err_pulse",     32'(bus.err_pulse),     m_err);
      check("timeout_pulse", 32'(bus.timeout_pulse), m_tmo);
   endtask

   task automatic step(input bit g, cf, cn, ch, input logic [4:0] coin,
                       input int code, input int qty);
      bus.sys_Goods    = g;
      bus.sys_Confirm  = cf;
      bus.sys_Cancel   = cn;
      bus.sys_Change   = ch;
      bus.coin_in      = coin;
      bus.type_SW_high = 3'(code / 10);
      bus.type_SW_low  = 3'(code % 10);
      bus.num_SW       = QTY_W'(qty);
      model_step(g, cf, cn, ch, coin, code, qty);
      @(posedge sys_clk);
      @(negedge sys_clk);
      compare_all();
   endtask

   task automatic goods(input int code, input int qty); step(1, 0, 0, 0, 5'b0, code, qty); endtask
   task automatic confirm();                            step(0, 1, 0, 0, 5'b0, 11, 1);     endtask
   task automatic cancel();                             step(0, 0, 1, 0, 5'b0, 11, 1);     endtask
   task automatic chg();                                step(0, 0, 0, 1, 5'b0, 11, 1);     endtask
   task automatic coin(input logic [4:0] c);            step(0, 0, 0, 0, c, 11, 1);        endtask
   task automatic idle();                               step(0, 0, 0, 0, 5'b0, 11, 1);     endtask

   task automatic do_reset();
      bus.sys_Goods = 0; bus.sys_Confirm = 0; bus.sys_Cancel = 0; bus.sys_Change = 0;
      bus.coin_in = '0;
      sys_rst_n = 1'b1;
      #1;
      model_reset();
      compare_all();
      check("rst_async_state",  32'(bus.state_out),    32'd1);
      check("rst_async_coin",   32'(bus.coin_out),     32'd0);
      check("rst_async_change", 32'(bus.change_money), 32'd0);
      check("rst_async_input",  32'(bus.input_money),  32'd0);
      @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      compare_all();
   endtask

   initial begin
      int r, code, qty;
      bit g, cf, cn, ch;
      logic [4:0] c;

      sys_rst_n = 1'b1;
      bus.sys_Goods = 0; bus.sys_Confirm = 0; bus.sys_Cancel = 0; bus.sys_Change = 0;
      bus.coin_in = '0; bus.type_SW_high = '0; bus.type_SW_low = '0; bus.num_SW = '0;
      model_reset();
      repeat (2) @(negedge sys_clk);
      compare_all();
      check("reset_state", 32'(bus.state_out), 32'd1);
      sys_rst_n = 1'b0;
      idle();

      // Cart build and pop
      confirm();
      check("sel_state", 32'(bus.state_out), 32'd2);
      goods(11, 3);
      goods(33, 2);
      check("cart_need39", 32'(bus.need_money), 32'd39);
      check("cart_count2", 32'(bus.item_count), 32'd2);
      cancel();
      check("pop_need9",   32'(bus.need_money), 32'd9);
      check("pop_count1",  32'(bus.item_count), 32'd1);

      // Full cart and unknown code
      goods(21, 1);
      goods(22, 1);
      goods(23, 1);
      check("full_count4", 32'(bus.item_count), 32'd4);
      goods(11, 1);
      check("full_err",    32'(bus.err_pulse),  32'd1);
      check("full_count",  32'(bus.item_count), 32'd4);
      goods(15, 1);
      check("code15_err",  32'(bus.err_pulse),  32'd1);
      check("code15_need", 32'(bus.need_money), 32'd36);
      goods(12, 0);
      check("qty0_err",    32'(bus.err_pulse),  32'd1);
      cancel(); cancel(); cancel();
      goods(33, 2);
      check("rebuild_need39", 32'(bus.need_money), 32'd39);

      // Payment and greedy change
      confirm();
      coin(5'b10000);
      coin(5'b00001);
      check("paid51", 32'(bus.input_money), 32'd51);
      confirm();
      check("change12", 32'(bus.change_money), 32'd12);
      chg();
      check("disp10_coin", 32'(bus.coin_out), 32'b00100);
      check("disp10_left", 32'(bus.change_money), 32'd2);
      chg();
      check("disp1a_coin", 32'(bus.coin_out), 32'b00001);
      chg();
      check("disp1b_left", 32'(bus.change_money), 32'd0);
      chg();
      check("back_idle",   32'(bus.state_out),  32'd1);
      check("idle_input0", 32'(bus.input_money), 32'd0);
      check("idle_need0",  32'(bus.need_money),  32'd0);

      // Hold and refund
      confirm();
      goods(21, 1);
      confirm();
      coin(5'b01000);
      cancel();
      check("hold_state", 32'(bus.state_out), 32'd8);
      coin(5'b10000);
      check("hold_coin_ignored", 32'(bus.input_money), 32'd20);
      confirm();
      check("refund20", 32'(bus.change_money), 32'd20);
      chg();
      check("refund_coin20", 32'(bus.coin_out), 32'b01000);
      chg();
      check("refund_idle", 32'(bus.state_out), 32'd1);

      // Money overflow and multi-bit coin
      confirm();
      goods(33, 3);
      confirm();
      repeat (5) coin(5'b10000);
      check("paid250", 32'(bus.input_money), 32'd250);
      coin(5'b00100);
      check("ovf_err",   32'(bus.err_pulse),   32'd1);
      check("ovf_keep",  32'(bus.input_money), 32'd250);
      coin(5'b00110);
      check("multibit_plus5", 32'(bus.input_money), 32'd255);
      confirm();
      check("change210", 32'(bus.change_money), 32'd210);
      chg();
      check("disp50", 32'(bus.coin_out), 32'b10000);
      do_reset();

`ifdef VENDING_PAY_TIMEOUT_EN
      confirm();
      goods(11, 1);
      confirm();
      coin(5'b00010);
      repeat (15) idle();
      check("tmo_not_yet", 32'(bus.timeout_pulse), 32'd0);
      check("tmo_still_pay", 32'(bus.state_out), 32'd4);
      idle();
      check("tmo_pulse",  32'(bus.timeout_pulse), 32'd1);
      check("tmo_state",  32'(bus.state_out),     32'd16);
      check("tmo_refund", 32'(bus.change_money),  32'd5);
      do_reset();
`endif

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         g = 0; cf = 0; cn = 0; ch = 0; c = '0;
         if (r < 20)      g  = 1;
         else if (r < 35) cf = 1;
         else if (r < 43) cn = 1;
         else if (r < 63) ch = 1;
         else if (r < 93) c  = 5'(1 << $urandom_range(0, 4));
         if ($urandom_range(0, 19) == 0) begin
            g  = g  | 1'($urandom_range(0, 1));
            cf = cf | 1'($urandom_range(0, 1));
            cn = cn | 1'($urandom_range(0, 1));
            c  = c  | 5'($urandom_range(0, 31));
         end
         if ($urandom_range(0, 9) == 0) code = int'($urandom_range(0, 7)) * 10 + int'($urandom_range(0, 7));
         else                           code = int'($urandom_range(1, 4)) * 10 + int'($urandom_range(1, 4));
         qty = int'($urandom_range(0, 3));
         step(g, cf, cn, ch, c, code, qty);
         if (n == 1500) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vending_cart_fsm.md
Name: vending_cart_fsm

Overview:
- Parametrised successor to the two-item vending controller.
- Holds a LIFO cart of up to MAX_ITEMS priced entries and accepts one-hot coin pulses with overflow rejection.
- Supports pop-last-item, a hold/refund path, and greedy one-coin-per-press change dispensing with explicit coin outputs.
- Sits between the debounced button/switch front end and the 7-segment/LED display driver.

Parameters:
- MAX_ITEMS, 4: cart depth (1..8).
- QTY_W, 2: quantity switch width.
- MONEY_W, 8: width of all money registers/ports.
- TIMEOUT_CYCLES, 100_000_000: payment inactivity limit; used only with PAY_TIMEOUT_EN.

Ports:
- sys_clk  in  1  single clock.
- sys_rst_n  in  1  reset, asynchronous and active-high despite the name.
- sys_Goods  in  1  add-item pulse.
- sys_Confirm  in  1  confirm pulse.
- sys_Cancel  in  1  cancel pulse.
- sys_Change  in  1  dispense-one-coin pulse.
- coin_in  in  5  one-hot coin pulses: bit0=1, bit1=5, bit2=10, bit3=20, bit4=50.
- type_SW_high  in  3  goods row.
- type_SW_low  in  3  goods column.
- num_SW  in  QTY_W  quantity.
- input_money  out  MONEY_W  accumulated coins.
- need_money  out  MONEY_W  cart total.
- change_money  out  MONEY_W  remaining change.
- item_count  out  $clog2(MAX_ITEMS+1)  cart occupancy.
- state_out  out  5  one-hot state.
- coin_out  out  5  one-hot dispensed coin, 1-cycle pulse.
- err_pulse  out  1  1-cycle pulse on any rejected add or coin.
- timeout_pulse  out  1  1-cycle pulse on payment timeout.

Behaviour:
- Reset: all outputs 0 except state_out=IDLE (5'b00001). Cart slots cleared. All outputs registered; each updates the cycle after the causing pulse.
- Buttons are pre-debounced single-cycle pulses. Simultaneous priority: sys_Cancel > sys_Confirm > sys_Goods. sys_Change is used only in CHANGE.
- States (one-hot): IDLE=01, SELECT=02, PAYMENT=04, HOLD=08, CHANGE=10.
- IDLE: money registers, cart and item_count held at 0. Confirm -> SELECT.
- SELECT, Goods: price = price_lookup({type_SW_high,type_SW_low}) * num_SW.
  - Accepted: price pushed to slot[item_count], item_count+1, need_money+=price.
  - Rejected with err_pulse, cart unchanged: unknown code (price 0), num_SW=0, item_count==MAX_ITEMS, or need_money+price > 2^MONEY_W-1.
- SELECT, Cancel: item_count>0 -> pop the last slot and subtract its price from need_money. item_count==0 -> IDLE.
- SELECT, Confirm: item_count>0 -> PAYMENT. Otherwise ignored.
- PAYMENT, coin_in: if several bits are set, only the lowest set bit counts. input_money+=denomination. If the sum would exceed 2^MONEY_W-1, the coin is rejected with err_pulse.
- PAYMENT, Confirm with input_money>=need_money -> CHANGE, change_money=input_money-need_money, loaded on the transition edge. Confirm with input_money<need_money: ignored.
- PAYMENT, Cancel -> HOLD.
- HOLD: Cancel -> PAYMENT (resume, money kept). Confirm -> CHANGE with change_money=input_money (full refund). Coins are ignored.
- CHANGE, sys_Change with change_money>0: select the largest denomination <= change_money; pulse the matching coin_out bit for 1 cycle; subtract it from change_money.
- CHANGE, sys_Change with change_money==0: -> IDLE, all registers cleared next cycle.
- Reset mid-operation: immediate return to the reset state. In-flight coin_out pulse is cleared.
- Default/illegal state encoding -> IDLE.

Optional Feature:
- Macro: VENDING_PAY_TIMEOUT_EN.
- Defined:
  - Counter runs in PAYMENT only; it clears on entry and on each accepted coin.
  - On reaching TIMEOUT_CYCLES-1: -> CHANGE with change_money=input_money (full refund) and timeout_pulse for 1 cycle.
  - Cancel or Confirm in the same cycle as expiry takes priority over the timeout.
- Undefined: no counter is synthesised; timeout_pulse is tied 0.

Decomposition:
- vending_pkg:
  - state one-hot constants.
  - denomination values {1,5,10,20,50} and coin index constants.
  - price_lookup function over the 16 goods codes: 11:3 12:4 13:6 14:3 21:10 22:8 23:9 24:7 31:4 32:6 33:15 34:8 41:9 42:4 43:5 44:5; any other code 0.
- Sub-module vending_change_dispenser: combinational greedy selector. Inputs change_money; outputs coin one-hot and denomination value. Instantiated once in the top FSM.

Test Plan:
- Confirm; code 11 qty3 Goods; code 33 qty2 Goods -> item_count=2, need_money=39. Cancel -> need_money=9, item_count=1.
- Add 5 items with MAX_ITEMS=4 -> 5th add gives err_pulse, item_count=4. Code 15 -> err_pulse, need unchanged.
- need=39; Confirm; coins 50,1 -> input_money=51. Confirm -> change_money=12. sys_Change x3 -> coin_out 10,1,1, change 2->1->0. 4th sys_Change -> IDLE.
- PAYMENT with input_money=20; Cancel -> HOLD; coin 50 -> ignored; Confirm -> change_money=20; dispense one 20; next press -> IDLE.
- input_money=250; coin 10 -> err_pulse, input stays 250. coin_in=5'b00110 -> +5 only.
- VENDING_PAY_TIMEOUT_EN, TIMEOUT_CYCLES=16: coin 5, then idle 16 cycles -> timeout_pulse, CHANGE with change_money=5. Reset asserted in CHANGE -> state_out=01, all money 0.
